guia_0701_checker: RTL

- Response-side consumer for the AND/NAND gate block. It accepts sample tuples (a, b, select, and_out, nand_out) over a valid/ready handshake and recomputes the expected result.
- select=0 selects AND; select=1 selects NAND.
- It tallies passes and fails, flags any and_out/nand_out pair that is not complementary, and captures the index of the first failing sample.
- It sits on the bench/self-check side, replacing manual reading of the printed monitor table.

---
 rtl/guia_0701_pkg.sv | 6 +
 rtl/guia_0701_expect.sv | 23 ++
 rtl/guia_0701_checker.sv | 103 ++++++++++
 3 files changed

// File: rtl/guia_0701_pkg.sv
// guia_0701_pkg: shared state encoding and select constants for the AND/NAND checker.
package guia_0701_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
    localparam logic SEL_AND  = 1'b0;
    localparam logic SEL_NAND = 1'b1;
endpackage

// File: rtl/guia_0701_expect.sv
// guia_0701_expect: combinational golden model of the AND/NAND gate for one sample.
module guia_0701_expect
    import guia_0701_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         select,
    input  logic [W-1:0] and_out,
    input  logic [W-1:0] nand_out,
    output logic [W-1:0] exp,
    output logic         obs_mismatch,
    output logic         compl_mismatch
);
    logic [W-1:0] obs;
    always_comb begin
        exp            = (select == SEL_NAND) ? ~(a & b) : (a & b);
        obs            = (select == SEL_NAND) ? nand_out : and_out;
        obs_mismatch   = obs != exp;
        compl_mismatch = and_out != ~nand_out;
    end
endmodule

// File: rtl/guia_0701_checker.sv
// guia_0701_checker: consumes AND/NAND sample tuples over valid/ready, tallies
// pass/fail, flags non-complementary outputs and captures the first failing index.
module guia_0701_checker
    import guia_0701_pkg::*;
#(
    parameter  int W         = 1,
    parameter  int N_SAMPLES = 4,
    localparam int CW        = $clog2(N_SAMPLES + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic          select,
    input  logic [W-1:0]  and_out,
    input  logic [W-1:0]  nand_out,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pass_count,
    output logic [CW-1:0] fail_count,
    output logic          compl_err,
    output logic          first_fail_valid,
    output logic [CW-1:0] first_fail_index
);
    state_e        state_q, state_d;
    logic [CW-1:0] pass_q, pass_d, fail_q, fail_d, idx_q, idx_d, ffi_q, ffi_d;
    logic          compl_q, compl_d, ffv_q, ffv_d;
    logic [W-1:0]  exp_unused;
    logic          obs_mismatch, compl_mismatch, sample_fail, accept;

    guia_0701_expect #(.W(W)) u_expect (
        .a              (a),
        .b              (b),
        .select         (select),
        .and_out        (and_out),
        .nand_out       (nand_out),
        .exp            (exp_unused),
        .obs_mismatch   (obs_mismatch),
        .compl_mismatch (compl_mismatch)
    );

    always_comb begin
        in_ready    = state_q == RUN;
        busy        = state_q == RUN;
        done        = state_q == DONE;
        accept      = in_ready && in_valid;
        sample_fail = obs_mismatch || compl_mismatch;
        state_d     = state_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        idx_d       = idx_q;
        compl_d     = compl_q;
        ffv_d       = ffv_q;
        ffi_d       = ffi_q;
        if (state_q != RUN && start) begin
            state_d = RUN;
            pass_d  = '0;
            fail_d  = '0;
            idx_d   = '0;
            compl_d = 1'b0;
            ffv_d   = 1'b0;
            ffi_d   = '0;
        end else if (accept) begin
            pass_d  = sample_fail ? pass_q : pass_q + CW'(1);
            fail_d  = sample_fail ? fail_q + CW'(1) : fail_q;
            compl_d = compl_q || compl_mismatch;
            ffv_d   = ffv_q || sample_fail;
            ffi_d   = (sample_fail && !ffv_q) ? idx_q : ffi_q;
            idx_d   = idx_q + CW'(1);
            // The last accept of the run closes it on the same edge.
            state_d = (idx_q == CW'(N_SAMPLES - 1)) ? DONE : RUN;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pass_q  <= '0;
            fail_q  <= '0;
            idx_q   <= '0;
            compl_q <= 1'b0;
            ffv_q   <= 1'b0;
            ffi_q   <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            idx_q   <= idx_d;
            compl_q <= compl_d;
            ffv_q   <= ffv_d;
            ffi_q   <= ffi_d;
        end
    end

    assign pass_count       = pass_q;
    assign fail_count       = fail_q;
    assign compl_err        = compl_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_index = ffi_q;
endmodule
